unidade_controle_partida: RTL and testbench

Parametrised game-sequencing control unit for the ultimate tic-tac-toe datapath, successor to the single-move macro/micro controller. It runs a full match rather than one move. It alternates players and validates each macro and micro selection against datapath flags, with retry on an invalid pick. It also enforces a per-move timeout, handles forced macro boards, counts moves and ends the match on win, draw or timeout.

---
 rtl/unidade_controle_partida.sv | 174 +++++++++++++++++
 tb/tb_unidade_controle_partida.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_partida.sv
// Match-level sequencer for ultimate tic-tac-toe: alternates players, validates
// macro/micro picks with retry, enforces a per-selection timeout and ends the match.
module unidade_controle_partida #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_JOGADAS    = 81,
    localparam int TW = $clog2(TIMEOUT_CYCLES),
    localparam int CW = $clog2(MAX_JOGADAS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          tem_jogada,
    input  logic          jogada_valida,
    input  logic          macro_livre,
    input  logic          fim_jogo,
    output logic          zeraR_macro,
    output logic          zeraR_micro,
    output logic          zeraEdge,
    output logic          registraR_macro,
    output logic          registraR_micro,
    output logic          carrega_macro_forcado,
    output logic          registra_tabuleiro,
    output logic          jogar_macro,
    output logic          jogar_micro,
    output logic          erro_jogada,
    output logic          jogador,
    output logic          tempo_esgotado,
    output logic          pronto,
    output logic [CW-1:0] contagem,
    output logic [3:0]    db_estado
);

    typedef enum logic [3:0] {
        E_INICIAL        = 4'd0,
        E_PREPARA        = 4'd1,
        E_JOGA_MACRO     = 4'd2,
        E_REGISTRA_MACRO = 4'd3,
        E_VALIDA_MACRO   = 4'd4,
        E_ERRO_MACRO     = 4'd5,
        E_JOGA_MICRO     = 4'd6,
        E_REGISTRA_MICRO = 4'd7,
        E_VALIDA_MICRO   = 4'd8,
        E_ERRO_MICRO     = 4'd9,
        E_GRAVA          = 4'd10,
        E_VERIFICA       = 4'd11,
        E_FORCA_MACRO    = 4'd12,
        E_TIMEOUT        = 4'd13,
        E_FIM            = 4'd14
    } estado_t;

    estado_t        r_estado, w_prox;
    logic [TW-1:0]  r_timer;
    logic [CW-1:0]  r_contagem;
    logic           r_jogador;
    logic           r_tempo_esgotado;
    logic           w_expira;
    logic           w_limite;
    logic           w_em_joga;
    logic           w_entra_joga;

    assign w_expira     = (r_timer == TW'(TIMEOUT_CYCLES - 1)) && !tem_jogada;
    assign w_limite     = (r_contagem == CW'(MAX_JOGADAS));
    assign w_em_joga    = (r_estado == E_JOGA_MACRO) || (r_estado == E_JOGA_MICRO);
    // Any transition into a wait state, including error retries, restarts the timer.
    assign w_entra_joga = ((w_prox == E_JOGA_MACRO) || (w_prox == E_JOGA_MICRO))
                          && (w_prox != r_estado);

    always_comb begin
        w_prox                = r_estado;
        zeraR_macro           = 1'b0;
        zeraR_micro           = 1'b0;
        zeraEdge              = 1'b0;
        registraR_macro       = 1'b0;
        registraR_micro       = 1'b0;
        carrega_macro_forcado = 1'b0;
        registra_tabuleiro    = 1'b0;
        jogar_macro           = 1'b0;
        jogar_micro           = 1'b0;
        erro_jogada           = 1'b0;
        pronto                = 1'b0;
        case (r_estado)
            E_INICIAL: begin
                zeraR_macro = 1'b1;
                zeraR_micro = 1'b1;
                zeraEdge    = 1'b1;
                if (iniciar) w_prox = E_PREPARA;
            end
            E_PREPARA: begin
                zeraR_macro = 1'b1;
                zeraR_micro = 1'b1;
                w_prox      = E_JOGA_MACRO;
            end
            E_JOGA_MACRO: begin
                jogar_macro = 1'b1;
                if (tem_jogada)    w_prox = E_REGISTRA_MACRO;
                else if (w_expira) w_prox = E_TIMEOUT;
            end
            E_REGISTRA_MACRO: begin
                registraR_macro = 1'b1;
                w_prox          = E_VALIDA_MACRO;
            end
            E_VALIDA_MACRO: w_prox = jogada_valida ? E_JOGA_MICRO : E_ERRO_MACRO;
            E_ERRO_MACRO: begin
                erro_jogada = 1'b1;
                w_prox      = E_JOGA_MACRO;
            end
            E_JOGA_MICRO: begin
                jogar_micro = 1'b1;
                if (tem_jogada)    w_prox = E_REGISTRA_MICRO;
                else if (w_expira) w_prox = E_TIMEOUT;
            end
            E_REGISTRA_MICRO: begin
                registraR_micro = 1'b1;
                w_prox          = E_VALIDA_MICRO;
            end
            E_VALIDA_MICRO: w_prox = jogada_valida ? E_GRAVA : E_ERRO_MICRO;
            E_ERRO_MICRO: begin
                erro_jogada = 1'b1;
                w_prox      = E_JOGA_MICRO;
            end
            E_GRAVA: begin
                registra_tabuleiro = 1'b1;
                w_prox             = E_VERIFICA;
            end
            E_VERIFICA: begin
                if (fim_jogo || w_limite) w_prox = E_FIM;
                else if (macro_livre)     w_prox = E_JOGA_MACRO;
                else                      w_prox = E_FORCA_MACRO;
            end
            E_FORCA_MACRO: begin
                carrega_macro_forcado = 1'b1;
                w_prox                = E_JOGA_MICRO;
            end
            E_TIMEOUT: w_prox = E_FIM;
            E_FIM: begin
                pronto = 1'b1;
                if (iniciar) w_prox = E_INICIAL;
            end
            default: w_prox = E_INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado         <= E_INICIAL;
            r_timer          <= '0;
            r_jogador        <= 1'b0;
            r_contagem       <= '0;
            r_tempo_esgotado <= 1'b0;
        end else begin
            r_estado <= w_prox;
            if (w_entra_joga)   r_timer <= '0;
            else if (w_em_joga) r_timer <= r_timer + 1'b1;
            case (r_estado)
                E_PREPARA: begin
                    r_jogador        <= 1'b0;
                    r_contagem       <= '0;
                    r_tempo_esgotado <= 1'b0;
                end
                E_GRAVA:    if (!w_limite) r_contagem <= r_contagem + 1'b1;
                // On timeout the player is left as-is: it identifies the loser.
                E_VERIFICA: if (!fim_jogo && !w_limite) r_jogador <= ~r_jogador;
                E_TIMEOUT:  r_tempo_esgotado <= 1'b1;
                default: ;
            endcase
        end
    end

    assign jogador        = r_jogador;
    assign contagem       = r_contagem;
    assign tempo_esgotado = r_tempo_esgotado;
    assign db_estado      = r_estado;

endmodule

// File: tb/tb_unidade_controle_partida.sv
// Directed + randomized bench for unidade_controle_partida; a match-level model
// (player, move count, forced-board flag, end flag) predicts every observation.
module tb_unidade_controle_partida;
    localparam int TC = 8;
    localparam int MJ = 4;

    logic clock = 1'b0;
    logic reset, iniciar, tem_jogada, jogada_valida, macro_livre, fim_jogo;
    logic zeraR_macro, zeraR_micro, zeraEdge, registraR_macro, registraR_micro;
    logic carrega_macro_forcado, registra_tabuleiro, jogar_macro, jogar_micro;
    logic erro_jogada, jogador, tempo_esgotado, pronto;
    logic [2:0] contagem;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int n_reg    = 0;
    int m_jog, m_cnt;
    bit m_end, m_forced;

    unidade_controle_partida #(.TIMEOUT_CYCLES(TC), .MAX_JOGADAS(MJ)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
        .jogada_valida(jogada_valida), .macro_livre(macro_livre), .fim_jogo(fim_jogo),
        .zeraR_macro(zeraR_macro), .zeraR_micro(zeraR_micro), .zeraEdge(zeraEdge),
        .registraR_macro(registraR_macro), .registraR_micro(registraR_micro),
        .carrega_macro_forcado(carrega_macro_forcado),
        .registra_tabuleiro(registra_tabuleiro), .jogar_macro(jogar_macro),
        .jogar_micro(jogar_micro), .erro_jogada(erro_jogada), .jogador(jogador),
        .tempo_esgotado(tempo_esgotado), .pronto(pronto), .contagem(contagem),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (registra_tabuleiro === 1'b1) n_reg++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a match; from fim the block passes through inicial first.
    task automatic start();
        iniciar = 1'b1;
        if (m_end) begin
            step();
            chk("fim->inicial", db_estado, 0);
            chk("pronto_inicial", pronto, 0);
        end
        step();
        chk("prepara", db_estado, 1);
        chk("zeraR_prepara", {zeraR_macro, zeraR_micro}, 2'b11);
        iniciar = 1'b0;
        step();
        chk("joga_macro_ini", db_estado, 2);
        chk("jogar_macro_ini", jogar_macro, 1);
        chk("jogador_ini", jogador, 0);
        chk("contagem_ini", contagem, 0);
        chk("pronto_ini", pronto, 0);
        chk("tempo_ini", tempo_esgotado, 0);
        m_jog = 0; m_cnt = 0; m_end = 0; m_forced = 0;
    endtask

    // One selection from a freshly entered wait state; idle up to TC-1 cycles
    // so the pulse may land in the expiry cycle and must still be accepted.
    task automatic pick(input bit micro, input bit ok);
        int idle;
        int base;
        idle = $urandom_range(0, TC - 1);
        base = micro ? 6 : 2;
        chk("joga_sel", db_estado, base);
        chk("jogar_sel", micro ? jogar_micro : jogar_macro, 1);
        repeat (idle) begin
            step();
            chk("espera_sel", db_estado, base);
        end
        tem_jogada = 1'b1;
        jogada_valida = ok;
        step();
        tem_jogada = 1'b0;
        chk("registra", db_estado, base + 1);
        chk("registraR", micro ? registraR_micro : registraR_macro, 1);
        step();
        chk("valida", db_estado, base + 2);
        chk("erro_valida", erro_jogada, 0);
        step();
        if (ok) begin
            chk("apos_valida", db_estado, micro ? 10 : 6);
        end else begin
            chk("erro_estado", db_estado, base + 3);
            chk("erro_pulso", erro_jogada, 1);
            chk("contagem_erro", contagem, m_cnt);
            step();
            chk("retry_estado", db_estado, base);
            chk("erro_fim", erro_jogada, 0);
        end
    endtask

    task automatic finish_move(input bit fj, input bit ml);
        chk("grava", db_estado, 10);
        chk("registra_tab", registra_tabuleiro, 1);
        chk("jogador_grava", jogador, m_jog);
        tem_jogada = 1'b1;
        fim_jogo = fj;
        macro_livre = ml;
        step();
        tem_jogada = 1'b0;
        m_cnt = (m_cnt < MJ) ? m_cnt + 1 : m_cnt;
        chk("verifica", db_estado, 11);
        chk("contagem", contagem, m_cnt);
        step();
        fim_jogo = 1'b0;
        macro_livre = 1'b1;
        if (fj || m_cnt == MJ) begin
            chk("fim", db_estado, 14);
            chk("pronto", pronto, 1);
            chk("jogador_fim", jogador, m_jog);
            m_end = 1;
        end else begin
            m_jog ^= 1;
            chk("jogador_troca", jogador, m_jog);
            if (ml) begin
                chk("prox_macro", db_estado, 2);
                chk("jogar_macro_prox", jogar_macro, 1);
            end else begin
                chk("forca", db_estado, 12);
                chk("carrega_forcado", carrega_macro_forcado, 1);
                step();
                chk("forca_micro", db_estado, 6);
                chk("carrega_fim", carrega_macro_forcado, 0);
                chk("sem_jogar_macro", jogar_macro, 0);
                chk("jogar_micro_f", jogar_micro, 1);
            end
            m_forced = !ml;
        end
    endtask

    task automatic timeout_case();
        repeat (TC - 1) begin
            step();
            chk("espera_to", db_estado, 2);
        end
        step();
        chk("timeout", db_estado, 13);
        step();
        chk("fim_to", db_estado, 14);
        chk("tempo_esgotado", tempo_esgotado, 1);
        chk("pronto_to", pronto, 1);
        chk("jogador_to", jogador, m_jog);
        chk("contagem_to", contagem, m_cnt);
        m_end = 1;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0; jogada_valida = 1'b0;
        macro_livre = 1'b1; fim_jogo = 1'b0;
        m_jog = 0; m_cnt = 0; m_end = 0; m_forced = 0;
        step();
        chk("rst_estado", db_estado, 0);
        chk("rst_zera", {zeraR_macro, zeraR_micro, zeraEdge}, 3'b111);
        chk("rst_pronto", pronto, 0);
        chk("rst_jogador", jogador, 0);
        chk("rst_contagem", contagem, 0);
        chk("rst_tempo", tempo_esgotado, 0);
        chk("rst_jogar", {jogar_macro, jogar_micro, erro_jogada}, 0);
        reset = 1'b0;
        step();
        chk("inicial_espera", db_estado, 0);

        // Four valid moves, free macro every time.
        start();
        n_reg = 0;
        repeat (MJ) begin
            pick(0, 1);
            pick(1, 1);
            finish_move(0, 1);
        end
        chk("n_registra", n_reg, MJ);
        chk("contagem_max", contagem, MJ);

        // Invalid micro then valid retry; then a pulse in the expiry cycle, then a timeout.
        start();
        pick(0, 1);
        pick(1, 0);
        pick(1, 1);
        finish_move(0, 1);
        repeat (TC - 1) begin
            step();
            chk("espera_limite", db_estado, 2);
        end
        tem_jogada = 1'b1;
        jogada_valida = 1'b1;
        step();
        tem_jogada = 1'b0;
        chk("aceita_limite", db_estado, 3);
        step();
        step();
        chk("limite_micro", db_estado, 6);
        pick(1, 1);
        finish_move(0, 1);
        timeout_case();

        // iniciar held from fim: inicial, prepara, joga_macro on consecutive edges.
        iniciar = 1'b1;
        step();
        chk("held_inicial", db_estado, 0);
        step();
        chk("held_prepara", db_estado, 1);
        step();
        chk("held_joga", db_estado, 2);
        chk("held_tempo", tempo_esgotado, 0);
        chk("held_contagem", contagem, 0);
        iniciar = 1'b0;
        m_jog = 0; m_cnt = 0; m_end = 0; m_forced = 0;

        // Forced macro board, then win after move 2.
        pick(0, 1);
        pick(1, 1);
        finish_move(0, 0);
        pick(1, 1);
        finish_move(1, 1);
        chk("fim_jogo_contagem", contagem, 2);

        // Reset mid-match in joga_micro.
        start();
        pick(0, 1);
        pick(1, 1);
        finish_move(0, 1);
        pick(0, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_estado", db_estado, 0);
        chk("rst_mid_contagem", contagem, 0);
        chk("rst_mid_jogador", jogador, 0);
        chk("rst_mid_zeraEdge", zeraEdge, 1);
        m_end = 0;

        // Randomized matches.
        repeat (4) begin
            start();
            while (!m_end) begin
                if (!m_forced) begin
                    repeat ($urandom_range(0, 2)) pick(0, 0);
                    pick(0, 1);
                end
                repeat ($urandom_range(0, 1)) pick(1, 0);
                pick(1, 1);
                finish_move(($urandom % 5) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
